jump_hazard_ctrl: RTL
=====================

JUMP_HAZARD_CTRL -- requirements
Module: jump_hazard_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NSRC, 2: ID-stage source operands checked (1..2; JR uses 1, branch compare uses 2).
- AW, 5: register address width.
- CW, 16: stall-cycle counter width.
- MAX_STALL, 15: consecutive stall cycles before timeout (1..2^CW-1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- id_valid, in, 1: JR or branch in ID needs register operands this cycle.
- id_src, in, NSRC*AW: source register numbers; src i occupies bits [i*AW +: AW].
- id_src_use, in, NSRC: per-source use mask.
- ex_regwrite, in, 1: instruction in ID/EX writes a register.
- ex_rd, in, AW: its final destination, rd/rt/31 already selected upstream.
- mem_regwrite, in, 1: EX/MEM write enable.
- mem_memread, in, 1: EX/MEM holds a load.
- mem_rd, in, AW: EX/MEM destination.
- mem_wait, in, 1: data memory not ready; the EX/MEM result is not final.
- wb_regwrite, in, 1: MEM/WB write enable.
- wb_rd, in, AW: MEM/WB destination.
- pipe_hold, in, 1: global pipeline freeze (cache miss).
- fwd_sel, out, 2*NSRC: per-source select, bits [2i+1:2i]; 00 regfile, 01 EX/MEM, 10 MEM/WB.
- stall, out, 1: hold PC and IF/ID, bubble ID/EX.
- id_go, out, 1: operands valid; branch/JR resolves this cycle.
- stall_busy, out, 1: registered; FSM in STALL state.
- stall_cnt, out, CW: saturating total of counted stall cycles.
- timeout, out, 1: sticky; a stall run reached MAX_STALL.

Function
REQ-003 Source i SHALL be active when id_valid=1, id_src_use[i]=1, and src i is not 0; register 0 SHALL never cause a stall or a forward.
REQ-004 An active source SHALL have an EX hazard when ex_regwrite=1 and ex_rd equals the source.
REQ-005 An active source SHALL have a MEM hazard when mem_rd equals the source and either mem_memread=1, or mem_wait=1 with mem_regwrite=1.
REQ-006 stall SHALL equal the OR of the EX and MEM hazards over all active sources, combinational in the same cycle; id_valid=0 SHALL force stall=0.
REQ-007 fwd_sel for source i SHALL be:
- 01 when mem_regwrite=1, mem_memread=0, mem_wait=0 and mem_rd matches;
- else 10 when wb_regwrite=1 and wb_rd matches;
- else 00.
An inactive source SHALL get 00. EX/MEM SHALL take priority over MEM/WB.
REQ-008 id_go SHALL equal id_valid AND NOT stall AND NOT pipe_hold.
REQ-009 The FSM SHALL have two states, RUN and STALL; stall_busy=1 exactly in STALL.
REQ-010 In RUN, a cycle with stall=1 and pipe_hold=0 SHALL move the FSM to STALL at the next edge; otherwise it stays in RUN.
REQ-011 In STALL, a cycle with stall=0 and pipe_hold=0 SHALL move the FSM to RUN at the next edge; otherwise it stays in STALL.
REQ-012 Each cycle with stall=1 and pipe_hold=0 SHALL increment stall_cnt by 1; stall_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-013 An internal run counter (CW bits) SHALL:
- increment under the same condition as stall_cnt;
- clear to 0 on any cycle with stall=0 and pipe_hold=0;
- hold when pipe_hold=1.
REQ-014 At the edge where the run counter goes from MAX_STALL-1 to MAX_STALL, timeout SHALL go to 1. It SHALL stay 1 until rst, and the run counter SHALL saturate at MAX_STALL.
REQ-015 pipe_hold=1 SHALL freeze the FSM state and all counters; stall and fwd_sel SHALL still be evaluated combinationally.
REQ-016 When a source matches both an EX hazard and a forwardable MEM/WB entry, stall SHALL be 1 and fwd_sel SHALL still show the MEM/WB select.

Reset
REQ-017 With rst=1 at a rising edge:
- FSM goes to RUN;
- stall_busy=0, stall_cnt=0, run counter=0, timeout=0;
- rst SHALL override pipe_hold and all hazard inputs.
REQ-018 Combinational outputs (stall, fwd_sel, id_go) SHALL follow their equations during reset; a reset asserted mid-stall SHALL clear stall_busy at the next edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- id_valid=1, src0=8, ex_regwrite=1, ex_rd=8 -> stall=1, id_go=0; next edge stall_busy=1, stall_cnt=1.
- src0=0, ex_rd=0, ex_regwrite=1 -> stall=0, fwd_sel=00, id_go=1.
- src1=9, mem_regwrite=1, mem_memread=0, mem_rd=9, wb_regwrite=1, wb_rd=9 -> fwd_sel[3:2]=01, stall=0.
- mem_memread=1, mem_rd=9 (src0=9) for 3 cycles, then clear -> stall_cnt=3, stall_busy falls one edge after the clear.
- MAX_STALL=4, hazard held 6 cycles with pipe_hold=1 on cycle 3 -> timeout rises after the 4th counted cycle; stall_cnt=5.
- CW=3, 10 counted stall cycles -> stall_cnt=7; rst=1 -> stall_cnt=0, timeout=0.

Source files
------------

// File: rtl/jump_hazard_ctrl.sv
// ID-stage hazard detection for JR/branch operands: stall generation, forward selection,
// stall bookkeeping and a sticky timeout on long stall runs.
module jump_hazard_ctrl #(
  parameter int unsigned NSRC      = 2,
  parameter int unsigned AW        = 5,
  parameter int unsigned CW        = 16,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_use,
  input  logic               ex_regwrite,
  input  logic [AW-1:0]      ex_rd,
  input  logic               mem_regwrite,
  input  logic               mem_memread,
  input  logic [AW-1:0]      mem_rd,
  input  logic               mem_wait,
  input  logic               wb_regwrite,
  input  logic [AW-1:0]      wb_rd,
  input  logic               pipe_hold,
  output logic [2*NSRC-1:0]  fwd_sel,
  output logic               stall,
  output logic               id_go,
  output logic               stall_busy,
  output logic [CW-1:0]      stall_cnt,
  output logic               timeout
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [CW-1:0] CntMax     = '1;
  localparam logic [CW-1:0] MaxStallC  = CW'(MAX_STALL);
  localparam logic [CW-1:0] MaxStallM1 = CW'(MAX_STALL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] run_q, run_d;
  logic          timeout_q, timeout_d;

  logic [NSRC-1:0] ex_haz, mem_haz;
  logic            mem_pending, mem_fwd_ok;

  // A load, or any write still waiting on memory, has no final value to forward yet.
  assign mem_pending = mem_memread | (mem_wait & mem_regwrite);
  assign mem_fwd_ok  = mem_regwrite & ~mem_memread & ~mem_wait;

  always_comb begin
    ex_haz  = '0;
    mem_haz = '0;
    fwd_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      logic [AW-1:0] src;
      logic          act;
      src = id_src[i*AW +: AW];
      act = id_valid & id_src_use[i] & (src != '0);
      ex_haz[i]  = act & ex_regwrite & (ex_rd == src);
      mem_haz[i] = act & mem_pending & (mem_rd == src);
      // Forward select is reported even when an EX hazard stalls the source.
      if (act && mem_fwd_ok && (mem_rd == src)) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end else if (act && wb_regwrite && (wb_rd == src)) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end
    end
  end

  assign stall = |(ex_haz | mem_haz);
  assign id_go = id_valid & ~stall & ~pipe_hold;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    if (!pipe_hold) begin
      state_d = stall ? StStall : StRun;
      if (stall) begin
        if (cnt_q != CntMax)     cnt_d     = cnt_q + 1'b1;
        if (run_q != MaxStallC)  run_d     = run_q + 1'b1;
        if (run_q == MaxStallM1) timeout_d = 1'b1;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_busy = (state_q == StStall);
  assign stall_cnt  = cnt_q;
  assign timeout    = timeout_q;

endmodule
